// File: rtl/gate_bist_pkg.sv
// Shared types, pattern-mode constants and the response folding function for the gate-model BIST.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } bist_state_e;

    localparam int unsigned PAT_EXHAUSTIVE = 0;
    localparam int unsigned PAT_LFSR       = 1;

    // XOR every sig_w-bit slice of the zero-extended out_w-bit response into one word.
    // Bit i of the response lands on signature bit (i mod sig_w).
    function automatic logic [31:0] fold(input logic [63:0] d,
                                         input int unsigned out_w,
                                         input int unsigned sig_w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < out_w) begin
                r[5'(i % sig_w)] = r[5'(i % sig_w)] ^ d[6'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_model_bist_if.sv
// Controller and gate-model facing signals of the BIST harness.
interface gate_model_bist_if #(
    parameter int unsigned IN_W  = 13,
    parameter int unsigned OUT_W = 10,
    parameter int unsigned SIG_W = 16,
    parameter int unsigned CNT_W = 14
);
    logic              start;
    logic              abort;
    logic [SIG_W-1:0]  golden_sig;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;
    logic [CNT_W-1:0]  pat_count;

    // Test controller plus gate model side.
    modport master (
        output start, abort, golden_sig, dut_out,
        input  dut_in, busy, done, pass, signature, pat_count
    );

    // BIST harness side.
    modport slave (
        input  start, abort, golden_sig, dut_out,
        output dut_in, busy, done, pass, signature, pat_count
    );
endinterface

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register compacting an OUT_W-bit response into SIG_W bits.
module gate_bist_misr
    import gate_bist_pkg::*;
#(
    parameter int unsigned SIG_W     = 16,
    parameter int unsigned OUT_W     = 10,
    parameter logic [31:0] MISR_POLY = 32'h0000_1021
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] d,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_next_c
);

    localparam logic [SIG_W-1:0] POLY = MISR_POLY[SIG_W-1:0];

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] fold_c;

    // Shift with feedback, then inject the folded response.
    always_comb begin
        fold_c     = SIG_W'(fold(64'(d), OUT_W, SIG_W));
        sig_next_c = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold_c;
    end

    // Signature register: clear wins over capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= sig_next_c;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/gate_model_bist.sv
// BIST harness: drives a gate model with counter or LFSR patterns and checks the MISR signature.
module gate_model_bist
    import gate_bist_pkg::*;
#(
    parameter int unsigned     IN_W      = 13,
    parameter int unsigned     OUT_W     = 10,
    parameter int unsigned     SIG_W     = 16,
    parameter int unsigned     PAT_MODE  = 0,
    parameter longint unsigned NUM_PAT   = 64'd1 << IN_W,
    parameter logic [31:0]     LFSR_POLY = 32'h0000_1B00,
    parameter logic [31:0]     LFSR_SEED = 32'd1,
    parameter logic [31:0]     MISR_POLY = 32'h0000_1021,
    parameter int unsigned     CNT_W     = $clog2(NUM_PAT + 1)
) (
    input logic               clk,
    input logic               rst_n,
    gate_model_bist_if.slave  bist_if
);

    localparam logic [IN_W-1:0]  LFSR_TAPS = LFSR_POLY[IN_W-1:0];
    localparam logic [IN_W-1:0]  SEED_RAW  = IN_W'(LFSR_SEED);
    // An all-zero LFSR state would lock up, so a zero seed becomes 1.
    localparam logic [IN_W-1:0]  SEED      = (SEED_RAW == '0) ? IN_W'(1) : SEED_RAW;
    localparam logic [IN_W-1:0]  FIRST_PAT = (PAT_MODE == PAT_LFSR) ? SEED : '0;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_PAT);

    bist_state_e      state_q;
    logic [IN_W-1:0]  dut_in_q;
    logic [IN_W-1:0]  pat_d;
    logic [CNT_W-1:0] pat_count_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             misr_clr;
    logic             misr_en;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_next_c;

    // Next stimulus pattern: binary increment or Galois LFSR step.
    always_comb begin
        pat_d = dut_in_q + IN_W'(1);
        if (PAT_MODE == PAT_LFSR) begin
            pat_d = {dut_in_q[IN_W-2:0], 1'b0} ^ (dut_in_q[IN_W-1] ? LFSR_TAPS : '0);
        end
    end

    // MISR is cleared leaving LOAD and captures every RUN cycle; abort freezes it.
    always_comb begin
        misr_clr = (state_q == LOAD) && !bist_if.abort;
        misr_en  = (state_q == RUN)  && !bist_if.abort;
    end

    // Run control FSM with registered status and stimulus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dut_in_q    <= '0;
            pat_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else if (bist_if.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bist_if.start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    state_q     <= RUN;
                    dut_in_q    <= FIRST_PAT;
                    pat_count_q <= CNT_W'(1);
                end
                RUN: begin
                    if (pat_count_q < LAST_CNT) begin
                        dut_in_q    <= pat_d;
                        pat_count_q <= pat_count_q + CNT_W'(1);
                    end else begin
                        // Final capture happens on this edge, so compare the MISR's next value.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (sig_next_c == bist_if.golden_sig);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    gate_bist_misr #(
        .SIG_W     (SIG_W),
        .OUT_W     (OUT_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (misr_clr),
        .en         (misr_en),
        .d          (bist_if.dut_out),
        .sig        (sig),
        .sig_next_c (sig_next_c)
    );

    assign bist_if.dut_in    = dut_in_q;
    assign bist_if.busy      = busy_q;
    assign bist_if.done      = done_q;
    assign bist_if.pass      = pass_q;
    assign bist_if.signature = sig;
    assign bist_if.pat_count = pat_count_q;

endmodule
